// File: rtl/lsu_pkg.sv
// LSU shared definitions: FSM states, access sizes, memory geometry.
// Also hosts the alignment check used at request accept.
package lsu_pkg;

   localparam int DM_AW = 16;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      RMW_RD,
      WRITE,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_t;

   function automatic logic misaligned(
      input logic [1:0] sz,
      input logic [1:0] a
   );
      logic m;
      m = 1'b0;
      case (sz)
         SZ_B:    m = 1'b0;
         SZ_H:    m = a[0];
         SZ_W:    m = |a;
         default: m = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extract/extend and store merge.
// Purely combinational; offsets are assumed already alignment-checked.
module lsu_align #(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_size,
   input  logic            i_unsigned,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_dm_out,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_ld_data,
   output logic [XLEN-1:0] o_st_word
);
   import lsu_pkg::*;

   logic [4:0]      w_sh;
   logic [XLEN-1:0] w_rot;
   logic [XLEN-1:0] w_mask;

   always_comb begin
      w_sh      = {i_off, 3'b000};
      w_rot     = i_dm_out >> w_sh;
      o_ld_data = i_dm_out;
      w_mask    = '1;
      case (i_size)
         SZ_B: begin
            o_ld_data = {{(XLEN-8){~i_unsigned & w_rot[7]}},
                         w_rot[7:0]};
            w_mask    = XLEN'(8'hFF) << w_sh;
         end
         SZ_H: begin
            o_ld_data = {{(XLEN-16){~i_unsigned & w_rot[15]}},
                         w_rot[15:0]};
            w_mask    = XLEN'(16'hFFFF) << w_sh;
         end
         default: begin
            o_ld_data = i_dm_out;
            w_mask    = '1;
         end
      endcase
      // Half shift equals byte shift once addr[0] is known zero
      o_st_word = (i_dm_out & ~w_mask) | ((i_wdata << w_sh) & w_mask);
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access to a word-wide data memory.
// Sub-word stores use read-modify-write; misaligned requests error out.
module lsu #(
   parameter int DM_AW = lsu_pkg::DM_AW,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             resp_valid,
   output logic [XLEN-1:0]  resp_rdata,
   output logic             resp_err,
   output logic             DM_enable,
   output logic             DM_write,
   output logic [DM_AW-1:0] DM_address,
   output logic [XLEN-1:0]  DM_in,
   input  logic [XLEN-1:0]  DM_out
);
   import lsu_pkg::*;

   state_t            r_state;
   state_t            w_nxt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [DM_AW+1:0]  r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_wbuf;
   logic [XLEN-1:0]   r_rdata;
   logic              r_err;
   logic              w_accept;
   logic              w_mis;
   logic [XLEN-1:0]   w_ld;
   logic [XLEN-1:0]   w_st;
   logic              w_unused;

   // Address bits above the memory window wrap away
   assign w_unused = ^{req_addr[XLEN-1:DM_AW+2], r_we};

   assign w_mis    = misaligned(req_size, req_addr[1:0]);
   assign w_accept = req_valid & req_ready;

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_off      (r_addr[1:0]),
      .i_dm_out   (DM_out),
      .i_wdata    (r_wdata),
      .o_ld_data  (w_ld),
      .o_st_word  (w_st)
   );

   always_comb begin
      w_nxt      = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      DM_enable  = 1'b0;
      DM_write   = 1'b0;
      DM_in      = '0;
      DM_address = r_addr[DM_AW+1:2];
      resp_rdata = r_rdata;
      resp_err   = r_err;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (w_accept) begin
               if (w_mis)
                  w_nxt = RESP;
               else if (!req_we)
                  w_nxt = READ;
               else if (req_size == SZ_W)
                  w_nxt = WRITE;
               else
                  w_nxt = RMW_RD;
            end
         end
         READ: begin
            DM_enable = 1'b1;
            w_nxt     = RESP;
         end
         RMW_RD: begin
            DM_enable = 1'b1;
            w_nxt     = WRITE;
         end
         WRITE: begin
            DM_enable = 1'b1;
            DM_write  = 1'b1;
            DM_in     = r_wbuf;
            w_nxt     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            w_nxt      = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wbuf  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr[DM_AW+1:0];
            r_wdata <= req_wdata;
            if (w_mis) begin
               r_err   <= 1'b1;
               r_rdata <= '0;
            end else if (req_we && req_size == SZ_W) begin
               r_wbuf <= req_wdata;
            end
         end
         case (r_state)
            READ: begin
               r_rdata <= w_ld;
               r_err   <= 1'b0;
            end
            RMW_RD: r_wbuf <= w_st;
            WRITE: begin
               r_rdata <= '0;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table with hand-computed results,
// plus back-to-back and reset-during-write sequences.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        DM_enable;
   logic        DM_write;
   logic [15:0] DM_address;
   logic [31:0] DM_in;
   logic [31:0] DM_out;

   logic [31:0] mem [0:65535];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu #(.DM_AW(16), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .DM_enable    (DM_enable),
      .DM_write     (DM_write),
      .DM_address   (DM_address),
      .DM_in        (DM_in),
      .DM_out       (DM_out)
   );

   assign DM_out = mem[DM_address];

   always @(posedge clk)
      if (DM_enable && DM_write)
         mem[DM_address] <= DM_in;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        mchk;
      logic [15:0] idx;
      logic [31:0] mval;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int  lat;
      int  en;
      bit  got;
      string tag;
      tag = $sformatf("v%0d", k);
      @(negedge clk);
      req_we       = v.we;
      req_size     = v.sz;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_valid    = 1'b1;
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      en  = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (resp_valid) got = 1'b1;
         else en += int'(DM_enable);
      end
      chk({tag, " lat"}, 32'(lat), 32'(v.lat));
      chk({tag, " err"}, 32'(resp_err), 32'(v.err));
      chk({tag, " rdata"}, resp_rdata, v.rdata);
      chk({tag, " en_cycles"}, 32'(en), v.err ? 32'd0 : 32'(v.lat - 1));
      @(negedge clk);
      chk({tag, " hold"}, resp_rdata, v.rdata);
      if (v.mchk)
         chk({tag, " mem"}, mem[v.idx], v.mval);
   endtask

   initial begin
      int nr;
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      mem[1] = 32'h0000_007F;
      mem[4] = 32'h8081_8283;
      mem[5] = 32'h1122_3344;
      mem[7] = 32'h0102_0304;

      //         we    sz    uns   addr          wdata         rdata         err  lat mchk idx  mval
      tbl[0]  = '{1'b0, SZ_B, 1'b0, 32'h11,      32'h0,        32'hFFFF_FF82, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[1]  = '{1'b0, SZ_H, 1'b1, 32'h12,      32'h0,        32'h0000_8081, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[2]  = '{1'b0, SZ_H, 1'b0, 32'h12,      32'h0,        32'hFFFF_8081, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[3]  = '{1'b0, SZ_B, 1'b1, 32'h13,      32'h0,        32'h0000_0080, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[4]  = '{1'b0, SZ_W, 1'b0, 32'h10,      32'h0,        32'h8081_8283, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[5]  = '{1'b0, SZ_B, 1'b0, 32'h10,      32'h0,        32'hFFFF_FF83, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[6]  = '{1'b1, SZ_B, 1'b0, 32'h13,      32'h0000_00AA, 32'h0,        1'b0, 3, 1'b1, 16'd4, 32'hAA81_8283};
      tbl[7]  = '{1'b1, SZ_W, 1'b0, 32'h22,      32'h1234_5678, 32'h0,        1'b1, 1, 1'b0, 16'd0, 32'h0};
      tbl[8]  = '{1'b0, SZ_H, 1'b0, 32'h11,      32'h0,        32'h0,        1'b1, 1, 1'b0, 16'd0, 32'h0};
      tbl[9]  = '{1'b0, SZ_X, 1'b0, 32'h10,      32'h0,        32'h0,        1'b1, 1, 1'b0, 16'd0, 32'h0};
      tbl[10] = '{1'b1, SZ_H, 1'b0, 32'h16,      32'hFFFF_1234, 32'h0,        1'b0, 3, 1'b1, 16'd5, 32'h1234_3344};
      tbl[11] = '{1'b1, SZ_W, 1'b0, 32'h18,      32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1'b1, 16'd6, 32'hDEAD_BEEF};
      tbl[12] = '{1'b0, SZ_W, 1'b0, 32'h18,      32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1'b0, 16'd0, 32'h0};
      tbl[13] = '{1'b0, SZ_W, 1'b0, 32'h4_0004,  32'h0,        32'h0000_007F, 1'b0, 2, 1'b0, 16'd0, 32'h0};

      rst          = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      #1;
      chk("rst ready", 32'(req_ready), 32'd1);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst rdata", resp_rdata, 32'h0);
      chk("rst err", 32'(resp_err), 32'd0);
      chk("rst en", 32'(DM_enable), 32'd0);
      chk("rst wr", 32'(DM_write), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

      // Back-to-back: valid held high, second request waits for IDLE
      @(negedge clk);
      req_we    = 1'b0;
      req_size  = SZ_W;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_addr = 32'h4_0004;
      @(negedge clk);
      chk("b2b ready n1", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("b2b resp1", 32'(resp_valid), 32'd1);
      chk("b2b ready n2", 32'(req_ready), 32'd0);
      chk("b2b rdata1", resp_rdata, 32'hAA81_8283);
      @(negedge clk);
      chk("b2b ready n3", 32'(req_ready), 32'd1);
      chk("b2b no resp n3", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b2b idx", 32'(DM_address), 32'd1);
      chk("b2b en", 32'(DM_enable), 32'd1);
      @(negedge clk);
      chk("b2b resp2", 32'(resp_valid), 32'd1);
      chk("b2b rdata2", resp_rdata, 32'h0000_007F);

      // Reset while WRITE is on the memory bus
      @(negedge clk);
      req_we    = 1'b1;
      req_size  = SZ_W;
      req_addr  = 32'h1C;
      req_wdata = 32'h5555_5555;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort wr before", 32'(DM_write), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort wr async", 32'(DM_write), 32'd0);
      chk("abort en async", 32'(DM_enable), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("abort mem", mem[7], 32'h0102_0304);
      chk("abort rdata", resp_rdata, 32'h0);
      nr = 0;
      repeat (4) begin
         @(negedge clk);
         nr += int'(resp_valid);
      end
      chk("abort no resp", 32'(nr), 32'd0);
      chk("abort ready", 32'(req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: DM_AW, default 16, DM word-address width.
REQ-002 Parameter: XLEN, default 32, data and byte-address width.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  MEM-stage access request.
REQ-006 Port: req_ready  out  1  LSU can accept a request.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port: req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 Port: req_addr  in  XLEN  byte address.
REQ-011 Port: req_wdata  in  XLEN  store data, right-aligned.
REQ-012 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-013 Port: resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-014 Port: resp_err  out  1  misaligned or illegal-size request; qualified by resp_valid.
REQ-015 Port: DM_enable, DM_write  out  1 each  data-memory controls.
REQ-016 Port: DM_address  out  DM_AW  word index = req_addr[DM_AW+1:2].
REQ-017 Port: DM_in  out  XLEN  memory write word.
REQ-018 Port: DM_out  in  XLEN  memory read word; combinational read, valid in the same cycle as the address.

Function
REQ-019 States SHALL be IDLE, READ, RMW_RD, WRITE and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready; every request field SHALL be registered at accept.
REQ-021 Misalignment SHALL be: half with addr[0]=1; word with addr[1:0]!=0; any size 11.
REQ-022 From IDLE on accept: misaligned -> RESP with err=1 and no DM access; load -> READ; word store -> WRITE with wbuf=wdata; byte/half store -> RMW_RD.
REQ-023 READ SHALL drive DM_enable=1, DM_write=0, capture the lane-extracted and extended DM_out, then go to RESP.
REQ-024 RMW_RD SHALL drive enable=1, write=0, merge the store lane(s) of wdata into DM_out (little-endian; byte lane = addr[1:0], half lane = addr[1]), store the result in wbuf, then go to WRITE.
REQ-025 WRITE SHALL drive enable=1, write=1, DM_in=wbuf, then go to RESP.
REQ-026 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE; resp_valid has no backpressure.
REQ-027 In IDLE and RESP, DM_enable and DM_write SHALL be 0; DM_in SHALL be 0 outside WRITE.
REQ-028 Latency from accept cycle N: error at N+1; load and word store at N+2; sub-word store at N+3.
REQ-029 Address bits above DM_AW+1 SHALL be ignored, so addresses wrap modulo 2^(DM_AW+2) bytes.
REQ-030 resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-031 While rst=0: state=IDLE; wbuf, the registered request, resp_rdata and resp_err = 0; resp_valid=0; DM_enable=DM_write=0.
REQ-032 Reset mid-operation SHALL abort the access immediately with no DM write and no response; the request is lost.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the state enum, the size encodings (SZ_B, SZ_H, SZ_W) and DM_AW.
REQ-034 One combinational sub-module, lsu_align, SHALL implement load extract/extend and store merge; the FSM stays in lsu.

Verification
REQ-035 Preload word 0x4 = 0x8081_8283; load byte, signed, addr 0x11 -> resp at N+2, rdata 0xFFFF_FF82, err 0.
REQ-036 Same word; load half, unsigned, addr 0x12 -> rdata 0x0000_8081.
REQ-037 Store byte 0xAA to addr 0x13 -> one read then one write of 0xAA81_8283 to index 4; resp at N+3.
REQ-038 Store word, addr 0x22 -> resp at N+1 with err 1; DM_enable never asserted.
REQ-039 Back-to-back req_valid held high -> req_ready low from N+1 until IDLE; second request accepted only after resp; addr 0x4_0004 (DM_AW=16) accesses index 1.
REQ-040 Assert rst=0 during WRITE -> DM_write drops asynchronously, memory is unchanged, and no resp_valid is produced.
